// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with optional same-cycle
// write forwarding, hardwired-zero register 0 and a background clear sequencer
// that walks every register to zero without a global reset.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                             clock,
  input  logic                             ctrl_reset,
  input  logic [NUM_WRITE-1:0]             ctrl_writeEnable,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  ctrl_writeReg,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]  data_writeReg,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   ctrl_readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0]   data_readReg,
  input  logic                             ctrl_clear,
  output logic                             status_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_idx, clr_idx_nxt;
  logic                    busy;

  logic [DATA_WIDTH-1:0]   regs [DEPTH];

  logic [ADDR_WIDTH-1:0]   wr_addr [NUM_WRITE];
  logic [DATA_WIDTH-1:0]   wr_data [NUM_WRITE];
  // wr_hit excludes ctrl_reset so the forwarding path has no reset dependency
  logic [NUM_WRITE-1:0]    wr_hit;
  logic [NUM_WRITE-1:0]    wr_commit;

  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_val;

  assign busy        = (state == CLEAR);
  assign status_busy = busy;

  // Unpack write ports and decide which ones are eligible to land this cycle
  always_comb begin
    wr_hit    = '0;
    wr_commit = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      wr_addr[w]   = ctrl_writeReg[w*ADDR_WIDTH +: ADDR_WIDTH];
      wr_data[w]   = data_writeReg[w*DATA_WIDTH +: DATA_WIDTH];
      wr_hit[w]    = ctrl_writeEnable[w] && !busy &&
                     !((ZERO_REG != 0) && (wr_addr[w] == '0));
      wr_commit[w] = wr_hit[w] && !ctrl_reset;
    end
  end

  // Clear sequencer next-state: start on request in IDLE, walk to the last index
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      IDLE: begin
        if (ctrl_clear) begin
          state_nxt   = CLEAR;
          clr_idx_nxt = '0;
        end
      end
      CLEAR: begin
        if (clr_idx == LAST_IDX) begin
          state_nxt = IDLE;
        end else begin
          clr_idx_nxt = clr_idx + ONE_IDX;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear sequencer state register; reset overrides any sequence in flight
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state   <= IDLE;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // Storage update: reset wipes all, clear zeroes one entry, else ports commit
  // in ascending order so the highest-index port wins an address conflict
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (busy) begin
      regs[clr_idx] <= '0;
    end else begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_commit[w]) begin
          regs[wr_addr[w]] <= wr_data[w];
        end
      end
    end
  end

  // Read ports: busy and register 0 force zero, otherwise forward or read array
  always_comb begin
    data_readReg = '0;
    rd_addr      = '0;
    rd_val       = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      rd_addr = ctrl_readReg[r*ADDR_WIDTH +: ADDR_WIDTH];
      rd_val  = regs[rd_addr];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (wr_hit[w] && (wr_addr[w] == rd_addr)) begin
            rd_val = wr_data[w];
          end
        end
      end
      if (busy || ((ZERO_REG != 0) && (rd_addr == '0))) begin
        rd_val = '0;
      end
      data_readReg[r*DATA_WIDTH +: DATA_WIDTH] = rd_val;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp. Two instances share stimulus,
// one with forwarding and one without; a behavioural model tracks contents
// and the busy window and is compared against both every cycle.
module tb_regfile_mp;

  logic        clock;
  logic        ctrl_reset;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic [9:0]  ra;
  logic [63:0] rdat;
  logic [63:0] rdat_nb;
  logic        clr;
  logic        busy;
  logic        busy_nb;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  // model state
  logic [31:0] mem [32];
  int          busy_left = 0;

  regfile_mp #(.BYPASS(1)) u_dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(we), .ctrl_writeReg(wa), .data_writeReg(wd),
    .ctrl_readReg(ra), .data_readReg(rdat),
    .ctrl_clear(clr), .status_busy(busy)
  );

  regfile_mp #(.BYPASS(0)) u_dut_nb (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(we), .ctrl_writeReg(wa), .data_writeReg(wd),
    .ctrl_readReg(ra), .data_readReg(rdat_nb),
    .ctrl_clear(clr), .status_busy(busy_nb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a busy countdown of 32 cycles, contents wiped when it ends
  always @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      busy_left <= 0;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) begin
        for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      end
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (we[w] && wa[w*5 +: 5] != 5'd0) mem[wa[w*5 +: 5]] <= wd[w*32 +: 32];
      end
      if (clr) busy_left <= 32;
    end
  end

  function automatic logic [31:0] model_read(input int r, input bit byp);
    logic [4:0]  a;
    logic [31:0] res;
    a = ra[r*5 +: 5];
    if (busy_left != 0) return 32'h0;
    if (a == 5'd0) return 32'h0;
    res = mem[a];
    if (byp) begin
      for (int w = 0; w < 2; w++) begin
        if (we[w] && wa[w*5 +: 5] == a) res = wd[w*32 +: 32];
      end
    end
    return res;
  endfunction

  // Per-cycle comparison of both instances against the model
  always @(negedge clock) begin
    if (started) begin
      for (int r = 0; r < 2; r++) begin
        check($sformatf("model_rd%0d", r), rdat[r*32 +: 32], model_read(r, 1'b1));
        check($sformatf("model_nb_rd%0d", r), rdat_nb[r*32 +: 32], model_read(r, 1'b0));
      end
      check("model_busy", {31'h0, busy}, {31'h0, busy_left != 0});
      check("model_busy_nb", {31'h0, busy_nb}, {31'h0, busy_left != 0});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
    we[p]          = en;
    wa[p*5 +: 5]   = a;
    wd[p*32 +: 32] = d;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    ra[p*5 +: 5] = a;
  endtask

  int cnt;

  initial begin
    ctrl_reset = 1'b1;
    we = '0; wa = '0; wd = '0; ra = '0; clr = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    started = 1;

    // reset then idle read
    set_rd(0, 5'd0); set_rd(1, 5'd7);
    @(negedge clock);
    check("rst_rd0", rdat[31:0], 32'h0);
    check("rst_rd7", rdat[63:32], 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    step();
    set_rd(0, 5'd31); set_rd(1, 5'd31);
    @(negedge clock);
    check("rst_rd31", rdat[31:0], 32'h0);

    // write / readback with zero register
    step();
    set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
    set_wr(1, 1'b1, 5'd0, 32'h12345678);
    set_rd(0, 5'd5); set_rd(1, 5'd0);
    @(negedge clock);
    check("byp_same_cycle", rdat[31:0], 32'hDEADBEEF);
    check("nobyp_same_cycle", rdat_nb[31:0], 32'h0);
    step();
    we = '0;
    @(negedge clock);
    check("wr_rd5", rdat[31:0], 32'hDEADBEEF);
    check("wr_rd0", rdat[63:32], 32'h0);
    check("wr_nb_rd5", rdat_nb[31:0], 32'hDEADBEEF);

    // conflict and bypass
    step();
    set_wr(0, 1'b1, 5'd9, 32'hAAAA0000);
    set_wr(1, 1'b1, 5'd9, 32'h0000BBBB);
    set_rd(0, 5'd9);
    @(negedge clock);
    check("conflict_byp", rdat[31:0], 32'h0000BBBB);
    check("conflict_nobyp_old", rdat_nb[31:0], 32'h0);
    step();
    we = '0;
    @(negedge clock);
    check("conflict_stored", rdat[31:0], 32'h0000BBBB);
    check("conflict_stored_nb", rdat_nb[31:0], 32'h0000BBBB);

    // top address, no aliasing onto low entries
    step();
    set_wr(0, 1'b1, 5'd31, 32'hCAFE0031);
    step();
    we = '0;
    set_rd(0, 5'd15); set_rd(1, 5'd31);
    @(negedge clock);
    check("top_rd31", rdat[63:32], 32'hCAFE0031);
    check("top_rd15", rdat[31:0], 32'h0);

    // fill 1..31 with index
    for (int i = 1; i < 32; i++) begin
      step();
      set_wr(0, 1'b1, 5'(i), 32'(i));
      set_rd(0, 5'(i));
    end
    step();
    we = '0;
    set_rd(0, 5'd17); set_rd(1, 5'd31);
    @(negedge clock);
    check("fill_rd17", rdat[31:0], 32'd17);
    check("fill_rd31", rdat[63:32], 32'd31);

    // clear sequence with a dropped write
    step();
    clr = 1'b1;
    set_rd(0, 5'd3); set_rd(1, 5'd17);
    step();
    clr = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (!busy) break;
      cnt++;
      step();
      if (cnt == 3) set_wr(0, 1'b1, 5'd3, 32'h00000333);
      else we = '0;
    end
    check("clear_busy_cycles", 32'(cnt), 32'd32);
    check("clear_rd3", rdat[31:0], 32'h0);
    check("clear_rd17", rdat[63:32], 32'h0);
    for (int a = 0; a < 32; a++) begin
      step();
      set_rd(0, 5'(a)); set_rd(1, 5'(31 - a));
    end

    // reset during the clear sequence
    step();
    set_wr(0, 1'b1, 5'd6, 32'h00000066);
    step();
    we = '0;
    clr = 1'b1;
    set_rd(0, 5'd6);
    step();
    clr = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (!busy) break;
      cnt++;
      if (cnt == 10) ctrl_reset = 1'b1;
      step();
      ctrl_reset = 1'b0;
    end
    check("midclr_busy_cycles", 32'(cnt), 32'd10);
    check("midclr_busy", {31'h0, busy}, 32'h0);
    check("midclr_rd6", rdat[31:0], 32'h0);
    step();
    set_wr(0, 1'b1, 5'd4, 32'h00000044);
    set_rd(1, 5'd4);
    step();
    we = '0;
    @(negedge clock);
    check("post_reset_wr", rdat[63:32], 32'h00000044);
    check("post_reset_wr_nb", rdat_nb[63:32], 32'h00000044);

    // clear and reset together
    step();
    clr = 1'b1;
    ctrl_reset = 1'b1;
    step();
    clr = 1'b0;
    ctrl_reset = 1'b0;
    @(negedge clock);
    check("clr_rst_busy", {31'h0, busy}, 32'h0);
    check("clr_rst_rd4", rdat[63:32], 32'h0);

    // second clear request during busy is ignored
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (!busy) break;
      cnt++;
      step();
      clr = (cnt == 5);
    end
    check("rereq_busy_cycles", 32'(cnt), 32'd32);

    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
